// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared definitions for the single-clock FIFO family.
//               - FIFO_MODE_REG / FIFO_MODE_FWFT : read-mode selector values
//               - fifo_params_legal()            : elaboration-time check
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_MODE_REG  = 0;  // registered read, 1-cycle read latency
    localparam int FIFO_MODE_FWFT = 1;  // first-word-fall-through

    // Returns 1 when the parameter set describes a buildable FIFO.
    function automatic bit fifo_params_legal(
        input int data_w,
        input int addr_w,
        input int af_th,
        input int ae_th,
        input int fwft
    );
        int depth;
        depth = 1 << addr_w;
        return (data_w >= 1) && (addr_w >= 1) && (addr_w <= 30) &&
               (af_th >= 1) && (af_th <= depth) &&
               (ae_th >= 0) && (ae_th <= depth - 1) &&
               ((fwft == FIFO_MODE_REG) || (fwft == FIFO_MODE_FWFT));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_mem
// Description : DATA_W x 2**ADDR_W storage array for sync_fifo.
//               Synchronous write, asynchronous read. Not reset.
// Ports       : clk        - clock
//               wr_en_i    - write strobe
//               wr_addr_i  - write address
//               wr_data_i  - write data
//               rd_addr_i  - read address
//               rd_data_o  - read data (combinational from rd_addr_i)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem_q [c_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            r_mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = r_mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count, programmable
//               almost-full/almost-empty thresholds, sticky overflow and
//               underflow flags, and registered or FWFT read mode.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               w_en, data_in       - write request and data
//               r_en                - read request (pop in FWFT mode)
//               err_clr             - clears overflow/underflow
//               data_out, data_valid- read data and its qualifier
//               full, empty         - occupancy == DEPTH / == 0
//               almost_full/_empty  - count >= AF_TH / count <= AE_TH
//               count               - occupancy 0..DEPTH
//               overflow, underflow - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int AF_TH  = (1 << ADDR_W) - 1,
    parameter int AE_TH  = 1,
    parameter int FWFT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              r_en,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int            c_DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] c_DEPTH_CNT = c_DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] c_AF_TH     = AF_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] c_AE_TH     = AE_TH[ADDR_W:0];

    if (!fifo_params_legal(DATA_W, ADDR_W, AF_TH, AE_TH, FWFT)) begin : g_param_err
        $error("sync_fifo: illegal parameter combination");
    end

    logic [ADDR_W-1:0] r_wptr_q, w_wptr_d;
    logic [ADDR_W-1:0] r_rptr_q, w_rptr_d;
    logic [ADDR_W:0]   r_count_q, w_count_d;
    logic              r_full_q, r_empty_q, r_afull_q, r_aempty_q;
    logic              r_ovf_q, w_ovf_d, r_unf_q, w_unf_d;
    logic              w_wacc, w_racc;
    logic [DATA_W-1:0] w_rd_data;

    // Acceptance uses the registered flags, so there is no pass-through
    // write-into-full or read-from-empty even when the other side is active.
    assign w_wacc = w_en & ~r_full_q;
    assign w_racc = r_en & ~r_empty_q;

    always_comb begin
        w_wptr_d  = w_wacc ? r_wptr_q + ADDR_W'(1) : r_wptr_q;
        w_rptr_d  = w_racc ? r_rptr_q + ADDR_W'(1) : r_rptr_q;
        w_count_d = r_count_q;
        case ({w_wacc, w_racc})
            2'b10:   w_count_d = r_count_q + (ADDR_W+1)'(1);
            2'b01:   w_count_d = r_count_q - (ADDR_W+1)'(1);
            default: w_count_d = r_count_q;
        endcase
        // A new error in the same cycle as err_clr wins.
        w_ovf_d = (r_ovf_q & ~err_clr) | (w_en & r_full_q);
        w_unf_d = (r_unf_q & ~err_clr) | (r_en & r_empty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr_q   <= '0;
            r_rptr_q   <= '0;
            r_count_q  <= '0;
            r_full_q   <= 1'b0;
            r_empty_q  <= 1'b1;
            r_afull_q  <= 1'b0;
            r_aempty_q <= 1'b1;
            r_ovf_q    <= 1'b0;
            r_unf_q    <= 1'b0;
        end else begin
            r_wptr_q   <= w_wptr_d;
            r_rptr_q   <= w_rptr_d;
            r_count_q  <= w_count_d;
            r_full_q   <= (w_count_d == c_DEPTH_CNT);
            r_empty_q  <= (w_count_d == '0);
            r_afull_q  <= (w_count_d >= c_AF_TH);
            r_aempty_q <= (w_count_d <= c_AE_TH);
            r_ovf_q    <= w_ovf_d;
            r_unf_q    <= w_unf_d;
        end
    end

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (w_wacc & ~rst),
        .wr_addr_i (r_wptr_q),
        .wr_data_i (data_in),
        .rd_addr_i (r_rptr_q),
        .rd_data_o (w_rd_data)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head of queue is always presented; r_en only advances the pointer.
        assign data_out   = w_rd_data;
        assign data_valid = ~r_empty_q;
    end else begin : g_reg
        logic [DATA_W-1:0] r_dout_q;
        logic              r_dvalid_q;

        // data_out keeps its last word when idle; only data_valid drops.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_dout_q   <= '0;
                r_dvalid_q <= 1'b0;
            end else begin
                r_dvalid_q <= w_racc;
                if (w_racc) begin
                    r_dout_q <= w_rd_data;
                end
            end
        end

        assign data_out   = r_dout_q;
        assign data_valid = r_dvalid_q;
    end

    assign full         = r_full_q;
    assign empty        = r_empty_q;
    assign almost_full  = r_afull_q;
    assign almost_empty = r_aempty_q;
    assign count        = r_count_q;
    assign overflow     = r_ovf_q;
    assign underflow    = r_unf_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo
// Description : Self-checking bench for sync_fifo. Two instances (registered
//               and FWFT read mode) share one stimulus stream; a queue-based
//               reference model supplies every expected value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

    localparam int c_DEPTH = 4;
    localparam int c_AF    = 3;
    localparam int c_AE    = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       w_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       r_en = 1'b0;
    logic       err_clr = 1'b0;

    logic [7:0] dout_r, dout_f;
    logic       dv_r, dv_f;
    logic       full_r, empty_r, af_r, ae_r, ovf_r, unf_r;
    logic       full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
    logic [2:0] cnt_r, cnt_f;

    always #5 clk = ~clk;

    sync_fifo #(.DATA_W(8), .ADDR_W(2), .AF_TH(3), .AE_TH(1), .FWFT(0)) dut_reg (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .err_clr(err_clr), .data_out(dout_r), .data_valid(dv_r), .full(full_r),
        .empty(empty_r), .almost_full(af_r), .almost_empty(ae_r), .count(cnt_r),
        .overflow(ovf_r), .underflow(unf_r)
    );

    sync_fifo #(.DATA_W(8), .ADDR_W(2), .AF_TH(3), .AE_TH(1), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .err_clr(err_clr), .data_out(dout_f), .data_valid(dv_f), .full(full_f),
        .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f), .count(cnt_f),
        .overflow(ovf_f), .underflow(unf_f)
    );

    // Reference model state
    logic [7:0] m_q[$];
    bit         m_ovf, m_unf, m_dv;
    logic [7:0] m_dout;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit we, input logic [7:0] din, input bit re,
                        input bit ec, input bit rs);
        bit was_full, was_empty;
        w_en    = we;
        data_in = din;
        r_en    = re;
        err_clr = ec;
        rst     = rs;
        @(posedge clk);
        if (rs) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_dv   = 1'b0;
            m_dout = 8'h00;
        end else begin
            was_full  = (m_q.size() == c_DEPTH);
            was_empty = (m_q.size() == 0);
            m_ovf = (m_ovf && !ec) || (we && was_full);
            m_unf = (m_unf && !ec) || (re && was_empty);
            m_dv  = re && !was_empty;
            if (re && !was_empty) begin
                m_dout = m_q.pop_front();
            end
            if (we && !was_full) begin
                m_q.push_back(din);
            end
        end
        #1;
        check("count",    32'(cnt_r),   32'(m_q.size()));
        check("full",     32'(full_r),  32'(m_q.size() == c_DEPTH));
        check("empty",    32'(empty_r), 32'(m_q.size() == 0));
        check("afull",    32'(af_r),    32'(m_q.size() >= c_AF));
        check("aempty",   32'(ae_r),    32'(m_q.size() <= c_AE));
        check("overflow", 32'(ovf_r),   32'(m_ovf));
        check("underflow",32'(unf_r),   32'(m_unf));
        check("reg_valid",32'(dv_r),    32'(m_dv));
        check("reg_dout", 32'(dout_r),  32'(m_dout));
        check("f_count",  32'(cnt_f),   32'(m_q.size()));
        check("f_ovf",    32'(ovf_f),   32'(m_ovf));
        check("f_unf",    32'(unf_f),   32'(m_unf));
        check("f_flags",  32'({full_f, empty_f, af_f, ae_f}),
              32'({m_q.size() == c_DEPTH, m_q.size() == 0,
                   m_q.size() >= c_AF, m_q.size() <= c_AE}));
        check("f_valid",  32'(dv_f),    32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("f_dout", 32'(dout_f), 32'(m_q[0]));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        m_ovf = 1'b0; m_unf = 1'b0; m_dv = 1'b0; m_dout = 8'h00;

        // Reset
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        // Fill: count 1..4, aempty falls after 2nd, afull after 3rd, full after 4th
        step(1, 8'h11, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0);
        step(1, 8'h33, 0, 0, 0);
        step(1, 8'h44, 0, 0, 0);
        // Write while full is dropped
        step(1, 8'h55, 0, 0, 0);
        // Drain, then read while empty
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0);
        step(0, 8'h00, 0, 0, 0);
        // Registered-read latency and hold
        step(1, 8'hA5, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        // Fall-through presentation, then pop
        step(1, 8'h3C, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        // Count 2 then 10 simultaneous read/write cycles across pointer wrap
        step(1, 8'h01, 0, 0, 0);
        step(1, 8'h02, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 8'(8'h03 + i), 1, 0, 0);
        // Count 3, reset with w_en high, then write/read pair
        step(1, 8'hE0, 0, 0, 0);
        step(1, 8'hEE, 0, 0, 1);
        step(1, 8'h77, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        // Error clear coinciding with a new error keeps the flag set
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 1, 0);
        step(0, 8'h00, 0, 1, 0);
        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(bit'($urandom_range(0, 1)), 8'($urandom),
                 bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 79) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
